mesi_receptor: RTL and testbench
================================

# mesi_receptor

Snoop-side MESI controller for one cache block. Watches the shared `BUS`, where other caches' emitters place 6-bit coherence words (two 3-bit ops: low field first, then high), and decides how the local copy reacts. It sits beside the local emitter in each cache:
- reads the block's current state from the emitter;
- returns state overrides;
- drives the shared, abort-memory and write-back signals.

## Interface
- `TAG_W`, default 8: width of the block address tag.

- `CLK`  in  1  clock; all logic is on the rising edge.
- `CLR`  in  1  reset; synchronous, active-low.
- `BUS`  in  6  coherence word `{op_hi, op_lo}`.
- `BUS_valid`  in  1  `BUS`/`BUS_tag` valid; sender holds it until accepted.
- `BUS_tag`  in  TAG_W  tag of the bus transaction.
- `blk_tag`  in  TAG_W  tag of the local block.
- `state_in`  in  3  current local state from the emitter.
- `wb_ack`  in  1  memory accepted the write-back.
- `state_out`  out  3  new state for the emitter.
- `state_we`  out  1  one-cycle strobe: emitter loads `state_out`.
- `shared`  out  1  one-cycle pulse: local copy exists (S/E/M hit on a read miss).
- `abort_mem`  out  1  one-cycle pulse: memory must not answer; the local M copy supplies the data.
- `wb_req`  out  1  write-back request, level.
- `err`  out  1  one-cycle pulse: illegal op code, or invalidate seen while in E/M.
- `busy`  out  1  transaction in progress.

## Operation
- Encodings:
  - states: I=001, S=010, E=011, M=100;
  - ops: 000 none, 001 read miss, 010 write miss, 011 write-back, 100 invalidate;
  - 101–111 are illegal.
- Accept when `BUS_valid && !busy`.
  - Capture `BUS`.
  - Capture hit = (`BUS_tag == blk_tag`).
  - Load the working state register from `state_in`.
- FSM states: IDLE, LO, HI, WB_WAIT.
- Ops are processed in the order LO then HI.
  - HI uses the working state as updated by LO, not `state_in`.
- Per-op rules, applied only on a hit. On a miss, all ops are no-ops, and `err` is still raised for illegal codes.
  - read miss:
    - I: no action.
    - S: `shared`.
    - E → S, `shared`.
    - M → S, `shared`, `abort_mem`, set the wb flag.
  - write miss:
    - I: no action.
    - S → I.
    - E → I.
    - M → I, `abort_mem`, set the wb flag.
  - write-back: no action.
  - invalidate:
    - S → I.
    - E → I, `err`.
    - M → I, `err`, set the wb flag.
    - I: no action.
  - none: no action; no strobe.
- `state_we` fires only when the working state actually changes.
- The wb flag is sticky per transaction, so at most one write-back is issued.

## Timing
- Reset (`CLR`=0 at an edge):
  - FSM goes to IDLE; the wb flag is cleared;
  - `state_out`=001;
  - `state_we`, `shared`, `abort_mem`, `wb_req`, `err`, `busy` = 0.
  - Reset mid-transaction drops `wb_req` at that edge; the transaction is discarded.
- Edge E0: accept; `busy`=1 from E0.
- LO result: outputs registered at E1, visible E1–E2.
- HI result: visible E2–E3.
- After HI:
  - wb flag clear: `busy`=0 at E3.
  - wb flag set: go to WB_WAIT; `wb_req`=1 from E3.
- WB_WAIT:
  - `wb_req` stays high until `wb_ack` is sampled 1.
  - At that edge, `wb_req`=0, `busy`=0, FSM → IDLE.
  - No timeout.
- Minimum transaction: 3 cycles.
- A new accept is possible at the first edge where `busy`=0. It cannot coincide with the edge that lowers `busy`, since `busy` is registered.
- `wb_ack` outside WB_WAIT is ignored.
- `BUS_valid` while busy is ignored; the sender keeps holding.
- `state_out` holds its last value between strobes.

## Structure
- `mesi_pkg` holds:
  - the state encodings and op encodings;
  - the FSM state localparams.
  - The emitter should switch to this package too.
- Sub-module `mesi_snoop_decode`: combinational map from (state, op, hit) to (next_state, change, shared, abort, wb, err).
  - Instantiated once and muxed between the LO and HI fields.
- Top level: capture registers, FSM, wb flag, output registers.

## Test plan
- Reset: hold `CLR`=0 for 2 cycles → `state_out`=001, all other outputs 0.
- Hit, `state_in`=E, `BUS`=000001 → at E1: `state_we`=1, `state_out`=010, `shared`=1; `busy`=0 at E3; no `wb_req`.
- Hit, `state_in`=M, `BUS`=010011 (LO write-back, HI write miss):
  - E1: no strobe.
  - E2: `state_out`=001, `abort_mem`=1.
  - `wb_req` from E3; `wb_ack` pulsed at E6 → `wb_req`=0, `busy`=0 at E6.
- Tag mismatch, `state_in`=S, `BUS`=000100 → no strobe, no pulses; `busy` 3 cycles.
- `state_in`=S, `BUS`=110100, hit:
  - E1: `state_out`=001.
  - E2: `err`=1, no strobe.
- Reset asserted while in WB_WAIT → `wb_req`=0 at that edge. A later `wb_ack` has no effect, and the next transaction is accepted normally.

Source files
------------

// File: rtl/mesi_pkg.sv
// ---------------------------------------------------------------------------
// mesi_pkg
//   Shared MESI encodings for the snoop-side receptor and the local emitter.
//   - ST_* : 3-bit cache block state codes (I/S/E/M)
//   - OP_* : 3-bit bus coherence op codes (101..111 are illegal)
//   - fsm_e : receptor transaction FSM states
//   - op_illegal() : flags op codes outside the legal set
// ---------------------------------------------------------------------------
package mesi_pkg;

  localparam logic [2:0] ST_I = 3'b001;
  localparam logic [2:0] ST_S = 3'b010;
  localparam logic [2:0] ST_E = 3'b011;
  localparam logic [2:0] ST_M = 3'b100;

  localparam logic [2:0] OP_NONE    = 3'b000;
  localparam logic [2:0] OP_RD_MISS = 3'b001;
  localparam logic [2:0] OP_WR_MISS = 3'b010;
  localparam logic [2:0] OP_WB      = 3'b011;
  localparam logic [2:0] OP_INV     = 3'b100;

  typedef enum logic [1:0] {
    FSM_IDLE,
    FSM_LO,
    FSM_HI,
    FSM_WB_WAIT
  } fsm_e;

  function automatic logic op_illegal(input logic [2:0] op);
    return (op > OP_INV);
  endfunction

endpackage

// File: rtl/mesi_snoop_decode.sv
// ---------------------------------------------------------------------------
// mesi_snoop_decode
//   Combinational reaction of one cache block to one snooped bus op.
//   Ports:
//     state_i      current working state of the block
//     op_i         3-bit bus op
//     hit_i        bus tag matches the local block
//     next_state_o state after applying the op
//     change_o     next_state_o differs from state_i
//     shared_o     local copy exists (read miss hit in S/E/M)
//     abort_o      memory must not answer, local M copy supplies data
//     wb_o         a write-back of the local M copy is required
//     err_o        illegal op, or invalidate seen while exclusive/modified
// ---------------------------------------------------------------------------
module mesi_snoop_decode
  import mesi_pkg::*;
(
  input  logic [2:0] state_i,
  input  logic [2:0] op_i,
  input  logic       hit_i,
  output logic [2:0] next_state_o,
  output logic       change_o,
  output logic       shared_o,
  output logic       abort_o,
  output logic       wb_o,
  output logic       err_o
);

  always_comb begin
    next_state_o = state_i;
    shared_o     = 1'b0;
    abort_o      = 1'b0;
    wb_o         = 1'b0;
    // Illegal codes are reported whether or not the tag matches.
    err_o        = op_illegal(op_i);

    if (hit_i) begin
      case (op_i)
        OP_RD_MISS: begin
          case (state_i)
            ST_S: shared_o = 1'b1;
            ST_E: begin
              next_state_o = ST_S;
              shared_o     = 1'b1;
            end
            ST_M: begin
              next_state_o = ST_S;
              shared_o     = 1'b1;
              abort_o      = 1'b1;
              wb_o         = 1'b1;
            end
            default: ;
          endcase
        end
        OP_WR_MISS: begin
          case (state_i)
            ST_S, ST_E: next_state_o = ST_I;
            ST_M: begin
              next_state_o = ST_I;
              abort_o      = 1'b1;
              wb_o         = 1'b1;
            end
            default: ;
          endcase
        end
        OP_INV: begin
          case (state_i)
            ST_S: next_state_o = ST_I;
            ST_E: begin
              next_state_o = ST_I;
              err_o        = 1'b1;
            end
            ST_M: begin
              next_state_o = ST_I;
              err_o        = 1'b1;
              wb_o         = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end

    change_o = (next_state_o != state_i);
  end

endmodule

// File: rtl/mesi_receptor.sv
// ---------------------------------------------------------------------------
// mesi_receptor
//   Snoop-side MESI controller for one cache block. Accepts a 6-bit
//   coherence word {op_hi, op_lo} from the shared bus, applies op_lo then
//   op_hi to a working copy of the local state, and reports the reaction.
//   Ports:
//     CLK        clock, rising edge
//     CLR        synchronous active-low reset
//     BUS        coherence word {op_hi, op_lo}
//     BUS_valid  BUS/BUS_tag valid, held by the sender until accepted
//     BUS_tag    tag of the bus transaction
//     blk_tag    tag of the local block
//     state_in   current local state from the emitter
//     wb_ack     memory accepted the write-back
//     state_out  new state for the emitter (holds between strobes)
//     state_we   one-cycle strobe: emitter loads state_out
//     shared     one-cycle pulse: local copy exists
//     abort_mem  one-cycle pulse: local M copy supplies the data
//     wb_req     write-back request, level
//     err        one-cycle pulse: illegal op / invalidate in E or M
//     busy       transaction in progress
// ---------------------------------------------------------------------------
module mesi_receptor
  import mesi_pkg::*;
#(
  parameter int unsigned TAG_W = 8
)
(
  input  logic             CLK,
  input  logic             CLR,
  input  logic [5:0]       BUS,
  input  logic             BUS_valid,
  input  logic [TAG_W-1:0] BUS_tag,
  input  logic [TAG_W-1:0] blk_tag,
  input  logic [2:0]       state_in,
  input  logic             wb_ack,
  output logic [2:0]       state_out,
  output logic             state_we,
  output logic             shared,
  output logic             abort_mem,
  output logic             wb_req,
  output logic             err,
  output logic             busy
);

  fsm_e       fsm_q, fsm_d;
  logic [5:0] word_q, word_d;
  logic       hit_q, hit_d;
  logic [2:0] work_q, work_d;
  logic       wb_flag_q, wb_flag_d;

  logic [2:0] state_out_q, state_out_d;
  logic       state_we_q, state_we_d;
  logic       shared_q, shared_d;
  logic       abort_q, abort_d;
  logic       wb_req_q, wb_req_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;

  logic       accept;
  logic       wb_done;
  logic [2:0] dec_op;
  logic [2:0] dec_next;
  logic       dec_change, dec_shared, dec_abort, dec_wb, dec_err;

  assign accept  = BUS_valid && !busy_q;
  assign wb_done = wb_req_q && wb_ack;

  // One decoder shared by both op slots; the FSM state selects the field.
  assign dec_op = (fsm_q == FSM_HI) ? word_q[5:3] : word_q[2:0];

  mesi_snoop_decode u_decode (
    .state_i      (work_q),
    .op_i         (dec_op),
    .hit_i        (hit_q),
    .next_state_o (dec_next),
    .change_o     (dec_change),
    .shared_o     (dec_shared),
    .abort_o      (dec_abort),
    .wb_o         (dec_wb),
    .err_o        (dec_err)
  );

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      fsm_q       <= FSM_IDLE;
      word_q      <= '0;
      hit_q       <= 1'b0;
      work_q      <= ST_I;
      wb_flag_q   <= 1'b0;
      state_out_q <= ST_I;
      state_we_q  <= 1'b0;
      shared_q    <= 1'b0;
      abort_q     <= 1'b0;
      wb_req_q    <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      word_q      <= word_d;
      hit_q       <= hit_d;
      work_q      <= work_d;
      wb_flag_q   <= wb_flag_d;
      state_out_q <= state_out_d;
      state_we_q  <= state_we_d;
      shared_q    <= shared_d;
      abort_q     <= abort_d;
      wb_req_q    <= wb_req_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic: FSM, capture registers, working state and wb flag.
  always_comb begin
    fsm_d     = fsm_q;
    word_d    = word_q;
    hit_d     = hit_q;
    work_d    = work_q;
    wb_flag_d = wb_flag_q;

    case (fsm_q)
      FSM_IDLE: begin
        if (accept) begin
          fsm_d     = FSM_LO;
          word_d    = BUS;
          hit_d     = (BUS_tag == blk_tag);
          work_d    = state_in;
          wb_flag_d = 1'b0;
        end
      end
      FSM_LO: begin
        fsm_d     = FSM_HI;
        work_d    = dec_next;
        wb_flag_d = wb_flag_q | dec_wb;
      end
      FSM_HI: begin
        // The FSM leaves HI at the edge that registers the HI result;
        // busy is held for one more cycle from the output logic, so the
        // IDLE cycle that follows still reads as busy and cannot accept.
        work_d    = dec_next;
        wb_flag_d = wb_flag_q | dec_wb;
        fsm_d     = (wb_flag_q | dec_wb) ? FSM_WB_WAIT : FSM_IDLE;
      end
      FSM_WB_WAIT: begin
        if (wb_done) begin
          fsm_d     = FSM_IDLE;
          wb_flag_d = 1'b0;
        end
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  // Output logic: values registered at the next edge.
  always_comb begin
    state_out_d = state_out_q;
    state_we_d  = 1'b0;
    shared_d    = 1'b0;
    abort_d     = 1'b0;
    wb_req_d    = 1'b0;
    err_d       = 1'b0;
    busy_d      = 1'b0;

    case (fsm_q)
      FSM_IDLE: begin
        busy_d = accept;
      end
      FSM_LO, FSM_HI: begin
        busy_d     = 1'b1;
        state_we_d = dec_change;
        shared_d   = dec_shared;
        abort_d    = dec_abort;
        err_d      = dec_err;
        if (dec_change) begin
          state_out_d = dec_next;
        end
      end
      FSM_WB_WAIT: begin
        // wb_ack only counts once the request is actually on the wire.
        busy_d   = !wb_done;
        wb_req_d = !wb_done;
      end
      default: ;
    endcase
  end

  assign state_out = state_out_q;
  assign state_we  = state_we_q;
  assign shared    = shared_q;
  assign abort_mem = abort_q;
  assign wb_req    = wb_req_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mesi_receptor.sv
// ---------------------------------------------------------------------------
// tb_mesi_receptor
//   Directed bench for mesi_receptor. Stimulus queues the expected output
//   snapshot for each upcoming clock edge; a monitor compares the DUT
//   outputs on the falling edge after that rising edge.
//   Snapshot flags are {state_we, shared, abort_mem, wb_req, err, busy}.
// ---------------------------------------------------------------------------
module tb_mesi_receptor;

  localparam logic [7:0] BLK = 8'h5A;
  localparam logic [7:0] OTHER = 8'hDB;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [5:0] BUS;
  logic       BUS_valid;
  logic [7:0] BUS_tag;
  logic [7:0] blk_tag;
  logic [2:0] state_in;
  logic       wb_ack;
  logic [2:0] state_out;
  logic       state_we;
  logic       shared;
  logic       abort_mem;
  logic       wb_req;
  logic       err;
  logic       busy;

  mesi_receptor #(.TAG_W(8)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .BUS       (BUS),
    .BUS_valid (BUS_valid),
    .BUS_tag   (BUS_tag),
    .blk_tag   (blk_tag),
    .state_in  (state_in),
    .wb_ack    (wb_ack),
    .state_out (state_out),
    .state_we  (state_we),
    .shared    (shared),
    .abort_mem (abort_mem),
    .wb_req    (wb_req),
    .err       (err),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  so;
    logic [5:0]  fl;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: compare every snapshot whose edge has been reached.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      vectors++;
      if (cur.cyc != cyc) begin
        miscompares++;
        $display("FAIL %s: snapshot for edge %0d checked late at edge %0d", cur.name, cur.cyc, cyc);
      end else if ({state_out, state_we, shared, abort_mem, wb_req, err, busy} !== {cur.so, cur.fl}) begin
        miscompares++;
        $display("FAIL %s: got state_out=%b we/sh/ab/wr/er/bz=%b, expected state_out=%b we/sh/ab/wr/er/bz=%b",
                 cur.name, state_out, {state_we, shared, abort_mem, wb_req, err, busy}, cur.so, cur.fl);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic expect_at(input int unsigned off, input logic [2:0] so, input logic [5:0] fl, input string name);
    exp_t e;
    e.cyc  = cyc + off;
    e.so   = so;
    e.fl   = fl;
    e.name = name;
    sb.push_back(e);
  endtask

  // Present one word for one edge, then scramble the inputs so the DUT
  // must rely on what it captured.
  task automatic send(input logic [5:0] w, input logic hitv, input logic [2:0] st);
    BUS       = w;
    BUS_tag   = hitv ? BLK : OTHER;
    state_in  = st;
    BUS_valid = 1'b1;
    tick();
    BUS_valid = 1'b0;
    BUS       = 6'b111111;
    BUS_tag   = ~BUS_tag;
    state_in  = 3'b000;
  endtask

  initial begin
    CLR = 1'b0; BUS = '0; BUS_valid = 1'b0; BUS_tag = '0;
    blk_tag = BLK; state_in = 3'b001; wb_ack = 1'b0;

    // Reset held for two edges.
    tick();
    expect_at(1, 3'b001, 6'b000000, "rst_a");
    expect_at(2, 3'b001, 6'b000000, "rst_b");
    tick(); tick();
    CLR = 1'b1;
    expect_at(1, 3'b001, 6'b000000, "idle_after_rst");
    tick();

    // Hit, E, LO read miss / HI none: E -> S with shared.
    expect_at(1, 3'b001, 6'b000001, "t1_e0");
    expect_at(2, 3'b010, 6'b110001, "t1_e1");
    expect_at(3, 3'b010, 6'b000001, "t1_e2");
    expect_at(4, 3'b010, 6'b000000, "t1_e3");
    send(6'b000_001, 1'b1, 3'b011);
    repeat (3) tick();

    // Tag miss, S, LO invalidate: no action, state_out holds.
    expect_at(1, 3'b010, 6'b000001, "miss_e0");
    expect_at(2, 3'b010, 6'b000001, "miss_e1");
    expect_at(3, 3'b010, 6'b000001, "miss_e2");
    expect_at(4, 3'b010, 6'b000000, "miss_e3");
    send(6'b000_100, 1'b0, 3'b010);
    repeat (3) tick();

    // Hit, E, invalidate twice: E -> I with err, then I stays I.
    expect_at(1, 3'b010, 6'b000001, "inv_e_e0");
    expect_at(2, 3'b001, 6'b100011, "inv_e_e1");
    expect_at(3, 3'b001, 6'b000001, "inv_e_e2");
    expect_at(4, 3'b001, 6'b000000, "inv_e_e3");
    send(6'b100_100, 1'b1, 3'b011);
    repeat (3) tick();

    // Sender holds BUS_valid: second accept at the first edge with busy=0.
    expect_at(1, 3'b001, 6'b000001, "hold_e0");
    expect_at(2, 3'b001, 6'b000001, "hold_e1");
    expect_at(3, 3'b001, 6'b000001, "hold_e2");
    expect_at(4, 3'b001, 6'b000000, "hold_e3");
    expect_at(5, 3'b001, 6'b000001, "hold_e4_reaccept");
    expect_at(6, 3'b001, 6'b000001, "hold_e5");
    expect_at(7, 3'b001, 6'b000001, "hold_e6");
    expect_at(8, 3'b001, 6'b000000, "hold_e7");
    BUS = 6'b000_001; BUS_tag = OTHER; state_in = 3'b010; BUS_valid = 1'b1;
    repeat (5) tick();
    BUS_valid = 1'b0;
    repeat (3) tick();

    // Hit, M, LO read miss then HI invalidate: M -> S -> I, single write-back.
    expect_at(1, 3'b001, 6'b000001, "m_rd_e0");
    expect_at(2, 3'b010, 6'b111001, "m_rd_e1");
    expect_at(3, 3'b001, 6'b100001, "m_rd_e2");
    expect_at(4, 3'b001, 6'b000101, "m_rd_e3_wbreq");
    expect_at(5, 3'b001, 6'b000101, "m_rd_e4_wbreq");
    expect_at(6, 3'b001, 6'b000000, "m_rd_e5_ack");
    send(6'b100_001, 1'b1, 3'b100);
    repeat (4) tick();
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;

    // Hit, S, LO invalidate / HI illegal 110.
    expect_at(1, 3'b001, 6'b000001, "s_ill_e0");
    expect_at(2, 3'b001, 6'b100001, "s_ill_e1");
    expect_at(3, 3'b001, 6'b000011, "s_ill_e2_err");
    expect_at(4, 3'b001, 6'b000000, "s_ill_e3");
    send(6'b110_100, 1'b1, 3'b010);
    repeat (3) tick();

    // Tag miss with illegal HI 111: err still raised.
    expect_at(1, 3'b001, 6'b000001, "miss_ill_e0");
    expect_at(2, 3'b001, 6'b000001, "miss_ill_e1");
    expect_at(3, 3'b001, 6'b000011, "miss_ill_e2_err");
    expect_at(4, 3'b001, 6'b000000, "miss_ill_e3");
    send(6'b111_000, 1'b0, 3'b010);
    repeat (3) tick();

    // Hit, M, LO write-back / HI write miss: abort at E2, ack at E6.
    expect_at(1, 3'b001, 6'b000001, "m_wm_e0");
    expect_at(2, 3'b001, 6'b000001, "m_wm_e1");
    expect_at(3, 3'b001, 6'b101001, "m_wm_e2");
    expect_at(4, 3'b001, 6'b000101, "m_wm_e3");
    expect_at(5, 3'b001, 6'b000101, "m_wm_e4");
    expect_at(6, 3'b001, 6'b000101, "m_wm_e5");
    expect_at(7, 3'b001, 6'b000000, "m_wm_e6_ack");
    expect_at(8, 3'b001, 6'b000000, "m_wm_e7");
    send(6'b010_011, 1'b1, 3'b100);
    repeat (5) tick();
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    tick();

    // Reset while waiting for the write-back; late wb_ack ignored.
    expect_at(1, 3'b001, 6'b000001, "rst_wb_e0");
    expect_at(2, 3'b001, 6'b101001, "rst_wb_e1");
    expect_at(3, 3'b001, 6'b000001, "rst_wb_e2");
    expect_at(4, 3'b001, 6'b000101, "rst_wb_e3");
    expect_at(5, 3'b001, 6'b000101, "rst_wb_e4");
    expect_at(6, 3'b001, 6'b000000, "rst_wb_e5_reset");
    expect_at(7, 3'b001, 6'b000000, "rst_wb_e6");
    expect_at(8, 3'b001, 6'b000000, "rst_wb_e7_lateack");
    expect_at(9, 3'b001, 6'b000000, "rst_wb_e8");
    send(6'b000_010, 1'b1, 3'b100);
    repeat (4) tick();
    CLR = 1'b0;
    tick();
    CLR = 1'b1;
    tick();
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    tick();

    // Normal transaction after the reset.
    expect_at(1, 3'b001, 6'b000001, "post_e0");
    expect_at(2, 3'b010, 6'b110001, "post_e1");
    expect_at(3, 3'b010, 6'b000001, "post_e2");
    expect_at(4, 3'b010, 6'b000000, "post_e3");
    send(6'b000_001, 1'b1, 3'b011);
    repeat (3) tick();

    repeat (20) begin
      if (sb.size() == 0) break;
      tick();
    end
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: never checked, expected state_out=%b flags=%b", cur.name, cur.so, cur.fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
